// File: rtl/count_ser_pkg.sv
// count_ser_pkg: shared types and constants for the count serializer.
//   cs_state_t     - frame state (IDLE / SEND)
//   CS_WIDTH       - default snapshot width in bits
//   CS_BYTE        - bits per streamed byte
//   cs_idx_width() - width of a byte index for a given byte count
//   CS_IDX_W       - byte-index width for the default snapshot width
package count_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } cs_state_t;

  localparam int CS_WIDTH = 64;
  localparam int CS_BYTE  = 8;

  // A single-byte frame still needs a one-bit index to keep port widths legal.
  function automatic int cs_idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  localparam int CS_IDX_W = cs_idx_width(CS_WIDTH / CS_BYTE);

endpackage

// File: rtl/count_ser_shreg.sv
// count_ser_shreg: snapshot register with a byte-wide right shifter.
//   clk, rst  - clock, asynchronous active-high reset (clears the register)
//   load      - capture din (takes priority over shift)
//   shift     - shift right by one byte, zero-filling from the top
//   din       - value to capture
//   byte_out  - least-significant byte of the register
module count_ser_shreg
  import count_ser_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [WIDTH-1:0]   din,
  output logic [CS_BYTE-1:0] byte_out
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      // Zero fill means the register reads as 0 once a frame is fully sent.
      q <= {{CS_BYTE{1'b0}}, q[WIDTH-1:CS_BYTE]};
    end
  end

  assign byte_out = q[CS_BYTE-1:0];

endmodule

// File: rtl/count_serializer.sv
// count_serializer: captures one of two wide counter values on Snap and
// streams it out LSB byte first over a valid/ready byte link.
//   Clk, Reset     - clock, asynchronous active-high reset
//   Count0/Count1  - counter values to choose from
//   Sel            - capture select (1 = Count1), sampled with an accepted Snap
//   Snap           - capture request
//   Out_Ready      - consumer ready
//   Clr_Overrun    - clears the sticky Overrun flag
//   Out_Data       - current byte
//   Out_Valid      - Out_Data is valid
//   Out_Last       - current byte is the final byte of the frame
//   Out_Sel        - Sel value latched with the frame
//   Busy           - frame in progress
//   Overrun        - sticky: a Snap arrived mid-frame and was dropped
// WIDTH must be a multiple of 8.
module count_serializer
  import count_ser_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Count0,
  input  logic [WIDTH-1:0] Count1,
  input  logic             Sel,
  input  logic             Snap,
  input  logic             Out_Ready,
  input  logic             Clr_Overrun,
  output logic [7:0]       Out_Data,
  output logic             Out_Valid,
  output logic             Out_Last,
  output logic             Out_Sel,
  output logic             Busy,
  output logic             Overrun
);

  localparam int NBYTES = WIDTH / CS_BYTE;
  localparam int IDX_W  = cs_idx_width(NBYTES);

  cs_state_t        state;
  cs_state_t        state_nxt;
  logic [IDX_W-1:0] idx;
  logic             last_byte;
  logic             xfer;
  logic             load;
  logic             ovr_set;
  logic [WIDTH-1:0] cap;

  assign last_byte = (idx == IDX_W'(NBYTES - 1));
  assign xfer      = (state == SEND) && Out_Ready;
  // A Snap is accepted when idle, or on the final transfer so frames abut.
  assign load      = Snap && ((state == IDLE) || (xfer && last_byte));
  assign ovr_set   = Snap && (state == SEND) && !(xfer && last_byte);
  assign cap       = Sel ? Count1 : Count0;

  count_ser_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk      (Clk),
    .rst      (Reset),
    .load     (load),
    .shift    (xfer),
    .din      (cap),
    .byte_out (Out_Data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Snap) state_nxt = SEND;
      SEND: if (xfer && last_byte) state_nxt = Snap ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Out_Valid = (state == SEND);
    Busy      = (state == SEND);
    Out_Last  = (state == SEND) && last_byte;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx     <= '0;
      Out_Sel <= 1'b0;
    end else if (load) begin
      idx     <= '0;
      Out_Sel <= Sel;
    end else if (xfer) begin
      idx     <= idx + 1'b1;
    end
  end

  // Set has priority over clear so a dropped Snap is never lost.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overrun <= 1'b0;
    end else if (ovr_set) begin
      Overrun <= 1'b1;
    end else if (Clr_Overrun) begin
      Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_serializer.sv
// tb_count_serializer: self-checking bench for count_serializer.
// Expected bytes are queued when a Snap is driven and compared whenever the
// DUT performs a transfer; table vectors and hand sequences check the rest.
module tb_count_serializer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] Count0 = '0;
  logic [63:0] Count1 = '0;
  logic        Sel = 1'b0;
  logic        Snap = 1'b0;
  logic        Out_Ready = 1'b0;
  logic        Clr_Overrun = 1'b0;
  logic [7:0]  Out_Data;
  logic        Out_Valid;
  logic        Out_Last;
  logic        Out_Sel;
  logic        Busy;
  logic        Overrun;

  count_serializer #(.WIDTH(64)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Count0      (Count0),
    .Count1      (Count1),
    .Sel         (Sel),
    .Snap        (Snap),
    .Out_Ready   (Out_Ready),
    .Clr_Overrun (Clr_Overrun),
    .Out_Data    (Out_Data),
    .Out_Valid   (Out_Valid),
    .Out_Last    (Out_Last),
    .Out_Sel     (Out_Sel),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       sel;
  } exp_t;

  typedef struct {
    logic [63:0] c0;
    logic [63:0] c1;
    logic        sel;
    logic        toggle;
    logic [63:0] exp;
    int          len;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame(input logic [63:0] value, input logic sel);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = value[8*i +: 8];
      e.last = (i == 7);
      e.sel  = sel;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy && n < 64) begin
      tick();
      n++;
    end
    if (Busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got Busy=1 after %0d cycles, required 0", name, n);
    end
  endtask

  // Scoreboard: inputs are stable between posedge+1 and the next posedge,
  // so valid && ready seen at the negedge is the transfer at the next edge.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && Out_Valid && Out_Ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got byte %0h, required no transfer", Out_Data);
      end else begin
        e = sbq.pop_front();
        check("sb_data", Out_Data, e.data);
        check("sb_last", Out_Last, e.last);
        check("sb_sel",  Out_Sel,  e.sel);
      end
    end
  end

  initial begin
    logic [7:0]  prev;
    logic [63:0] v;
    int          cyc;

    vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 8};
    vecs[1] = '{64'h0, 64'hFFEE_DDCC_BBAA_9988, 1'b1, 1'b1, 64'hFFEE_DDCC_BBAA_9988, 15};
    vecs[2] = '{64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 64'h0, 8};
    vecs[3] = '{64'hA5A5_5A5A_0F0F_F0F0, 64'h8000_0000_0000_0001, 1'b1, 1'b0,
                64'h8000_0000_0000_0001, 8};

    // Reset state
    #1;
    check("rst_data",    Out_Data,  8'h00);
    check("rst_valid",   Out_Valid, 1'b0);
    check("rst_last",    Out_Last,  1'b0);
    check("rst_sel",     Out_Sel,   1'b0);
    check("rst_busy",    Busy,      1'b0);
    check("rst_overrun", Overrun,   1'b0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("idle_valid", Out_Valid, 1'b0);

    // Table-driven frames
    for (int k = 0; k < 4; k++) begin
      Count0    = vecs[k].c0;
      Count1    = vecs[k].c1;
      Sel       = vecs[k].sel;
      Out_Ready = 1'b0;
      Snap      = 1'b1;
      push_frame(vecs[k].exp, vecs[k].sel);
      tick();
      Snap = 1'b0;
      Sel  = ~Sel;
      check("vec_byte0_valid", Out_Valid, 1'b1);
      check("vec_byte0_data",  Out_Data,  vecs[k].exp[7:0]);
      cyc = 0;
      while (Busy && cyc < 40) begin
        Out_Ready = vecs[k].toggle ? (cyc[0] == 1'b0) : 1'b1;
        prev = Out_Data;
        tick();
        if (!Out_Ready) begin
          check("stall_hold_data",  Out_Data,  prev);
          check("stall_hold_valid", Out_Valid, 1'b1);
        end
        cyc++;
      end
      Out_Ready = 1'b0;
      check("vec_frame_len",  cyc, vecs[k].len);
      check("vec_sb_empty",   sbq.size(), 0);
      check("vec_idle_data",  Out_Data,  8'h00);
      check("vec_idle_valid", Out_Valid, 1'b0);
      check("vec_overrun",    Overrun,   1'b0);
    end

    // Overrun: Snap on the 3rd byte is dropped, frame unaltered
    Count0 = 64'h1122_3344_5566_7788;
    Sel = 1'b0;
    Out_Ready = 1'b1;
    Snap = 1'b1;
    push_frame(Count0, 1'b0);
    tick();
    Snap = 1'b0;
    Count0 = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    tick();
    check("ovr_byte2", Out_Data, 8'h66);
    Snap = 1'b1;
    tick();
    Snap = 1'b0;
    check("ovr_set",  Overrun, 1'b1);
    check("ovr_busy", Busy,    1'b1);
    wait_idle("ovr_frame");
    check("ovr_sticky", Overrun, 1'b1);
    check("ovr_sb_empty", sbq.size(), 0);
    Clr_Overrun = 1'b1;
    tick();
    Clr_Overrun = 1'b0;
    check("ovr_clear", Overrun, 1'b0);

    // Simultaneous set and clear: set wins
    Count0 = 64'h0F1E_2D3C_4B5A_6978;
    Snap = 1'b1;
    push_frame(Count0, 1'b0);
    tick();
    Snap = 1'b1;
    Clr_Overrun = 1'b1;
    tick();
    Snap = 1'b0;
    Clr_Overrun = 1'b0;
    check("ovr_set_wins", Overrun, 1'b1);
    wait_idle("ovr2_frame");
    Clr_Overrun = 1'b1;
    tick();
    Clr_Overrun = 1'b0;
    check("ovr_clear2", Overrun, 1'b0);

    // Back-to-back: Snap on the last-byte transfer cycle
    Count0 = 64'hAAAA_BBBB_CCCC_DDDD;
    Snap = 1'b1;
    push_frame(Count0, 1'b0);
    tick();
    Snap = 1'b0;
    cyc = 0;
    while (!Out_Last && cyc < 16) begin
      tick();
      cyc++;
    end
    check("b2b_last_seen", Out_Last, 1'b1);
    Count1 = 64'h1357_9BDF_0246_8ACE;
    Sel = 1'b1;
    Snap = 1'b1;
    push_frame(Count1, 1'b1);
    tick();
    Snap = 1'b0;
    check("b2b_valid",   Out_Valid, 1'b1);
    check("b2b_byte0",   Out_Data,  8'hCE);
    check("b2b_last",    Out_Last,  1'b0);
    check("b2b_outsel",  Out_Sel,   1'b1);
    check("b2b_overrun", Overrun,   1'b0);
    wait_idle("b2b_frame");
    check("b2b_sb_empty", sbq.size(), 0);

    // Reset mid-frame
    Count0 = 64'h8877_6655_4433_2211;
    Sel = 1'b0;
    Snap = 1'b1;
    push_frame(Count0, 1'b0);
    tick();
    Snap = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_byte4", Out_Data, 8'h55);
    Reset = 1'b1;
    sbq.delete();
    #1;
    check("mid_rst_valid", Out_Valid, 1'b0);
    check("mid_rst_busy",  Busy,      1'b0);
    check("mid_rst_data",  Out_Data,  8'h00);
    tick();
    Reset = 1'b0;
    tick();
    check("post_rst_valid", Out_Valid, 1'b0);
    check("post_rst_data",  Out_Data,  8'h00);
    Count0 = 64'h0000_0000_0000_C0DE;
    Snap = 1'b1;
    push_frame(Count0, 1'b0);
    tick();
    Snap = 1'b0;
    check("post_rst_byte0", Out_Data, 8'hDE);
    wait_idle("post_rst_frame");
    check("post_rst_sb_empty", sbq.size(), 0);

    // Capture instant: counter advances every cycle
    Count0 = 64'h0000_00FF_FFFF_FFFD;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        Snap = 1'b1;
        v = Count0;
        push_frame(v, 1'b0);
      end
      tick();
      Snap = 1'b0;
      Count0 = Count0 + 64'd1;
    end
    cyc = 0;
    while (Busy && cyc < 64) begin
      tick();
      Count0 = Count0 + 64'd1;
      cyc++;
    end
    check("cap_idle", Busy, 1'b0);
    check("cap_sb_empty", sbq.size(), 0);

    Out_Ready = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/count_serializer.md
# count_serializer

Downstream stage of the dual 64-bit event counter, whose `Output0` and `Output1` feed this block's `Count0` and `Count1` ports. On a `Snap` pulse it captures one counter, chosen by `Sel`, into a snapshot register. It then streams the snapshot out one byte at a time, least-significant byte first, over a valid/ready handshake. The block lets the wide counter values leave the design over a narrow byte link without stalling the counter.

## Interface
- `WIDTH`, 64: snapshot width; must be a multiple of 8.
- `NBYTES`, WIDTH/8: bytes per frame; derived, not overridable.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: asynchronous, active-high reset.
- `Count0` input WIDTH: counter value 0 (upstream `Output0`).
- `Count1` input WIDTH: counter value 1 (upstream `Output1`).
- `Sel` input 1: capture select; 0 selects Count0, 1 selects Count1; sampled only with an accepted Snap.
- `Snap` input 1: capture request, sampled every edge.
- `Out_Ready` input 1: consumer ready.
- `Clr_Overrun` input 1: clears `Overrun`.
- `Out_Data` output 8: current byte.
- `Out_Valid` output 1: `Out_Data` is valid.
- `Out_Last` output 1: current byte is byte NBYTES-1.
- `Out_Sel` output 1: `Sel` value latched with the frame.
- `Busy` output 1: a frame is in progress (state SEND).
- `Overrun` output 1: sticky flag; a Snap was dropped.

## Operation
- States: IDLE and SEND. Snapshot shift register `shreg[WIDTH-1:0]`. Byte index `idx` of width clog2(NBYTES).
- IDLE, Snap=1:
  - `shreg` takes `Sel ? Count1 : Count0`.
  - `Out_Sel` takes `Sel`.
  - `idx` goes to 0; state goes to SEND.
- SEND outputs:
  - `Out_Valid` = 1.
  - `Out_Data` = `shreg[7:0]`.
  - `Out_Last` = (idx == NBYTES-1).
  - `Busy` = 1.
- Transfer occurs when `Out_Valid && Out_Ready`. On a transfer, `shreg` shifts right by 8, zero-filled, and `idx` increments.
- Transfer on the last byte: state returns to IDLE. If Snap=1 in that same cycle, a new capture occurs and state stays SEND with idx=0. Back-to-back frames therefore leave no gap.
- Snap in SEND, other than on the last-byte transfer cycle: request is ignored and `Overrun` is set to 1. The current frame is unaffected.
- `Overrun` is cleared by `Clr_Overrun`. If a set and a clear land in the same cycle, set wins.
- Stall (SEND, Out_Ready=0): `Out_Data`, `Out_Last`, `Out_Sel` and `Out_Valid` hold unchanged.
- IDLE outputs: `Out_Valid`, `Out_Last` and `Busy` are 0. `Out_Data` is 0, driven from the cleared/shifted-out register.

## Timing
- Reset values: state=IDLE, shreg=0, idx=0. All outputs 0: `Out_Data`, `Out_Valid`, `Out_Last`, `Out_Sel`, `Busy`, `Overrun`.
- Reset asserted mid-frame aborts the frame immediately (asynchronously). No partial byte is presented after Reset deasserts.
- Latency: Snap sampled at edge n gives `Out_Valid`=1 from edge n, i.e. byte 0 is visible in cycle n+1. Byte 0 is bits [7:0] of the count as it was at edge n.
- With `Out_Ready` held at 1, a frame takes exactly NBYTES cycles, and `Out_Last` is high in the NBYTES-th cycle.
- `Out_Valid` never drops mid-frame without a transfer of the last byte or a Reset.
- All outputs are registered or decoded from registers only. There is no combinational path from `Out_Ready` or `Snap` to any output.

## Structure
- Shared package `count_ser_pkg` holds:
  - the state enum (IDLE, SEND);
  - `CS_WIDTH` = 64 and `CS_BYTE` = 8;
  - a `clog2`-based index-width constant.
- One sub-module is natural: `count_ser_shreg`, covering the snapshot register plus right shifter with load/shift enables. The FSM, index counter and Overrun logic stay in the top module.

## Test plan
- **Basic frame:** Count0=64'h0123_4567_89AB_CDEF, Sel=0, Snap pulse, Out_Ready=1.
  - Out_Data sequence: EF, CD, AB, 89, 67, 45, 23, 01 over 8 cycles.
  - Out_Last only on 01; Busy low the cycle after.
- **Backpressure:** Sel=1, Count1=64'hFFEE_DDCC_BBAA_9988, Out_Ready toggling 1/0.
  - Each byte is held stable while Ready=0.
  - Frame completes after 8 transfers; Out_Sel=1 throughout.
- **Overrun:** Snap again at the 3rd byte of a frame.
  - Frame continues unaltered and Overrun=1.
  - Clr_Overrun pulse returns Overrun to 0.
  - Simultaneous set and clear leaves Overrun=1.
- **Back-to-back:** Snap asserted on the last-byte transfer cycle.
  - Next cycle presents byte 0 of the new snapshot.
  - Out_Valid stays 1 with no gap; Overrun stays 0.
- **Reset mid-frame:** assert Reset during byte 4.
  - Out_Valid, Busy and Out_Data drop to 0 at once.
  - After deassert, a new Snap starts a clean frame from byte 0.
- **Capture instant:** counter incrementing every cycle, Snap at edge n.
  - Streamed value equals the count at edge n, not at any later edge.
